// File: rtl/brs_op_sched.sv
// brs_op_sched: two-requester scheduler for one registered XOR/AND unit with valid/ready responses.
// Define BRS_SCHED_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module brs_op_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic             busy,
   output logic             last_grant
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic op_q, owner, win0, win1, acc, idle;
`ifdef BRS_SCHED_RR_EN
   assign win1 = req1_valid & (~req0_valid | ~last_grant);
`else
   assign win1 = req1_valid & ~req0_valid;
`endif
   assign win0 = req0_valid & ~win1;
   // ready is gated by rst_n so it reads 0 while reset is held
   assign idle = rst_n & (state == IDLE);
   assign req0_ready = idle & win0;
   assign req1_ready = idle & win1;
   assign acc = req0_ready | req1_ready;
   assign busy = state != IDLE;
   assign rsp0_valid = (state == RESP) & ~owner;
   assign rsp1_valid = (state == RESP) & owner;
   assign rsp0_data = rsp0_valid ? res_q : '0;
   assign rsp1_data = rsp1_valid ? res_q : '0;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = acc ? EXEC : IDLE;
         EXEC: state_nx = RESP;
         RESP: state_nx = (owner ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q <= '0;
         b_q <= '0;
         op_q <= 1'b0;
         res_q <= '0;
         owner <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nx;
         if (acc) begin
            a_q <= win1 ? req1_a : req0_a;
            b_q <= win1 ? req1_b : req0_b;
            op_q <= win1 ? req1_op : req0_op;
            owner <= win1;
            last_grant <= win1;
         end
         if (state == EXEC)
            res_q <= op_q ? (a_q & b_q) : (a_q ^ b_q);
      end
   end
endmodule

// File: tb/tb_brs_op_sched.sv
// tb_brs_op_sched: randomized and directed stimulus against a transaction-level scheduler model.
// Expected responses are queued on accept and popped by an independent response monitor.
module tb_brs_op_sched;
   logic clk, rst_n;
   logic req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
   logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
   logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy, last_grant;
   int checks = 0, errors = 0;
   logic [8:0] q[$];
   bit pend, own, lg = 1'b1;
   int age;

   brs_op_sched #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .busy(busy), .last_grant(last_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] bitop(input logic [7:0] a, input logic [7:0] b, input logic o);
      return o ? (a & b) : (a ^ b);
   endfunction

   // Reference model: one operation in flight, response two cycles after accept, held until taken.
   always @(negedge clk) begin
      bit w, any, erv0, erv1;
      if (!rst_n) begin
         pend = 1'b0;
         lg = 1'b1;
         q.delete();
         chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, last_grant, rsp0_data, rsp1_data},
             {5'b0, 1'b1, 16'h0});
      end else begin
         chk("last_grant", last_grant, lg);
         if (pend) age++;
         erv0 = pend && age >= 2 && !own;
         erv1 = pend && age >= 2 && own;
         chk("busy", busy, pend);
         chk("rsp_valid", {rsp1_valid, rsp0_valid}, {erv1, erv0});
         if (pend) begin
            chk("ready_while_busy", {req1_ready, req0_ready}, 2'b00);
            if ((erv0 && rsp0_ready) || (erv1 && rsp1_ready)) pend = 1'b0;
         end else begin
            any = req0_valid || req1_valid;
`ifdef BRS_SCHED_RR_EN
            w = (req0_valid && req1_valid) ? !lg : req1_valid;
`else
            w = req0_valid ? 1'b0 : req1_valid;
`endif
            chk("grant", {req1_ready, req0_ready}, any ? (w ? 2'b10 : 2'b01) : 2'b00);
            if (any) begin
               q.push_back({w, w ? bitop(req1_a, req1_b, req1_op) : bitop(req0_a, req0_b, req0_op)});
               pend = 1'b1;
               age = 0;
               own = w;
               lg = w;
            end
         end
      end
   end

   task automatic check_rsp(input bit n, input logic [7:0] d, input logic rdy);
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_unexpected requester=%0d actual=%0h expected=none", n, d);
      end else begin
         chk("rsp_owner", n, q[0][8]);
         chk("rsp_data", d, q[0][7:0]);
         if (rdy) void'(q.pop_front());
      end
   endtask

   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         if (rsp0_valid) check_rsp(1'b0, rsp0_data, rsp0_ready);
         else chk("rsp0_idle_data", rsp0_data, 8'h00);
         if (rsp1_valid) check_rsp(1'b1, rsp1_data, rsp1_ready);
         else chk("rsp1_idle_data", rsp1_data, 8'h00);
      end
   end

   // Presents one operation and returns at posedge+1 of the cycle after its accept.
   task automatic issue(input bit n, input logic [7:0] a, input logic [7:0] b, input logic o);
      bit got = 1'b0;
      if (n) begin req1_a = a; req1_b = b; req1_op = o; req1_valid = 1'b1; end
      else begin req0_a = a; req0_b = b; req0_op = o; req0_valid = 1'b1; end
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         got = n ? req1_ready : req0_ready;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout requester=%0d actual=no_ready expected=ready", n);
      end
      @(posedge clk);
      #1;
      if (n) req1_valid = 1'b0;
      else req0_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         done = !busy;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy expected=idle");
      end
      @(posedge clk);
      #1;
   endtask

   // Random traffic: valid held until accepted; pv/pr are tenths probability of valid / rsp ready.
   task automatic run(input int n, input int pv, input int pr);
      bit a0, a1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         @(posedge clk);
         #1;
         if (!req0_valid || a0) begin
            req0_valid = $urandom_range(0, 9) < pv;
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom);
         end
         if (!req1_valid || a1) begin
            req1_valid = $urandom_range(0, 9) < pv;
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom);
         end
         rsp0_ready = $urandom_range(0, 9) < pr;
         rsp1_ready = $urandom_range(0, 9) < pr;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      wait_idle();
   endtask

   initial begin
      rst_n = 1'b0;
      {req0_valid, req0_op, req1_valid, req1_op, rsp0_ready, rsp1_ready} = '0;
      {req0_a, req0_b, req1_a, req1_b} = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      issue(1'b0, 8'h5A, 8'h0F, 1'b0);
      wait_idle();
      rsp1_ready = 1'b0;
      issue(1'b1, 8'hF0, 8'h3C, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rsp1_ready = 1'b1;
      wait_idle();
      issue(1'b0, 8'hFF, 8'hFF, 1'b0); wait_idle();
      issue(1'b1, 8'hFF, 8'hFF, 1'b1); wait_idle();
      issue(1'b0, 8'h00, 8'hFF, 1'b0); wait_idle();
      issue(1'b1, 8'h00, 8'hFF, 1'b1); wait_idle();
      issue(1'b0, 8'h81, 8'h7E, 1'b0);
      issue(1'b1, 8'hC3, 8'h99, 1'b1);
      wait_idle();
      run(30, 10, 10);
      rsp0_ready = 1'b0;
      issue(1'b0, 8'h12, 8'h34, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_op", {rsp0_valid, busy, last_grant, rsp0_data}, {1'b0, 1'b0, 1'b1, 8'h00});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp0_ready = 1'b1;
      issue(1'b0, 8'hA5, 8'h3C, 1'b1);
      wait_idle();
      run(600, 6, 7);
      run(40, 10, 10);
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
